// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate prescaler, X/Y raster counters and
// registered blank/sync/strobe outputs for the VGA colour client and monitor pins.
module vga_timing_gen #(
    parameter int PIX_DIV   = 2,
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic        CLK_100MHz,
    input  logic        Reset_n,
    input  logic        Enable,
    output logic [10:0] CurrentX,
    output logic [10:0] CurrentY,
    output logic        HBlank,
    output logic        VBlank,
    output logic        HSync,
    output logic        VSync,
    output logic        PixelTick,
    output logic        FrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int PRE_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PIX_DIV - 1);
    localparam logic [10:0]      X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      Y_LAST   = 11'(V_TOTAL - 1);

    // Thresholds are 12 bits so a 2048-wide raster can still express its end bound.
    localparam logic [11:0] HB_START = 12'(H_VISIBLE);
    localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] VB_START = 12'(V_VISIBLE);
    localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        HS_ACT   = (HSYNC_POL != 0);
    localparam logic        VS_ACT   = (VSYNC_POL != 0);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
        end
        if (PIX_DIV < 1 || PIX_DIV > 15) begin : g_bad_div
            $error("vga_timing_gen: PIX_DIV must be in 1..15");
        end
    endgenerate

    logic [PRE_W-1:0] prescaler;
    logic             advance;
    logic [10:0]      x_next;
    logic [10:0]      y_next;
    logic             frame_wrap;
    logic             hblank_next;
    logic             vblank_next;
    logic             hsync_next;
    logic             vsync_next;

    assign advance = Enable && (prescaler == PRE_LAST);

    // Outputs are computed from the post-advance position so they land on the counter edge.
    always_comb begin
        x_next     = CurrentX + 11'd1;
        y_next     = CurrentY;
        frame_wrap = 1'b0;
        if (CurrentX == X_LAST) begin
            x_next = '0;
            if (CurrentY == Y_LAST) begin
                y_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                y_next = CurrentY + 11'd1;
            end
        end
        hblank_next = ({1'b0, x_next} >= HB_START);
        vblank_next = ({1'b0, y_next} >= VB_START);
        hsync_next  = ({1'b0, x_next} >= HS_START && {1'b0, x_next} < HS_END) ? HS_ACT : ~HS_ACT;
        vsync_next  = ({1'b0, y_next} >= VS_START && {1'b0, y_next} < VS_END) ? VS_ACT : ~VS_ACT;
    end

    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            prescaler  <= '0;
            CurrentX   <= '0;
            CurrentY   <= '0;
            HBlank     <= 1'b0;
            VBlank     <= 1'b0;
            HSync      <= ~HS_ACT;
            VSync      <= ~VS_ACT;
            PixelTick  <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            PixelTick  <= advance;
            FrameStart <= advance && frame_wrap;
            // Prescaler holds while disabled so the pixel phase resumes exactly.
            if (Enable) begin
                prescaler <= advance ? '0 : prescaler + PRE_W'(1);
            end
            if (advance) begin
                CurrentX <= x_next;
                CurrentY <= y_next;
                HBlank   <= hblank_next;
                VBlank   <= vblank_next;
                HSync    <= hsync_next;
                VSync    <= vsync_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-geometry line/enable/reset checks plus
// small-geometry scoreboarded frames at PIX_DIV=3 and PIX_DIV=1 with inverted sync polarity.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
    logic en_b_q = 1'b1;

    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic hb_a, vb_a, hs_a, vs_a, pt_a, fs_a;
    logic hb_b, vb_b, hs_b, vs_b, pt_b, fs_b;
    logic hb_c, vb_c, hs_c, vs_c, pt_c, fs_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fs_cnt_b = 0, fs_cyc1 = 0, fs_cyc2 = 0;

    logic [26:0] q_b[$];
    logic [26:0] q_c[$];

    vga_timing_gen u_dut_a (
        .CLK_100MHz(clk), .Reset_n(rst_a), .Enable(en_a),
        .CurrentX(x_a), .CurrentY(y_a), .HBlank(hb_a), .VBlank(vb_a),
        .HSync(hs_a), .VSync(vs_a), .PixelTick(pt_a), .FrameStart(fs_a)
    );

    vga_timing_gen #(
        .PIX_DIV(3), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_dut_b (
        .CLK_100MHz(clk), .Reset_n(rst_b), .Enable(en_b),
        .CurrentX(x_b), .CurrentY(y_b), .HBlank(hb_b), .VBlank(vb_b),
        .HSync(hs_b), .VSync(vs_b), .PixelTick(pt_b), .FrameStart(fs_b)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) u_dut_c (
        .CLK_100MHz(clk), .Reset_n(rst_c), .Enable(en_c),
        .CurrentX(x_c), .CurrentY(y_c), .HBlank(hb_c), .VBlank(vb_c),
        .HSync(hs_c), .VSync(vs_c), .PixelTick(pt_c), .FrameStart(fs_c)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Small raster: 17 x 9, sync at X=12..14 and Y=6..7, blank from X=10 / Y=5.
    function automatic logic [26:0] exp_word(input int k, input logic pol);
        int pos, x, y;
        logic hb, vb, hs, vs, fs;
        pos = k % 153;
        x   = pos % 17;
        y   = pos / 17;
        hb  = (x >= 10);
        vb  = (y >= 5);
        hs  = (x >= 12 && x <= 14) ? pol : ~pol;
        vs  = (y >= 6 && y <= 7) ? pol : ~pol;
        fs  = (pos == 0);
        return {fs, hs, vs, hb, vb, 11'(y), 11'(x)};
    endfunction

    always @(posedge clk) begin
        cyc++;
        en_b_q <= en_b;
    end

    always @(negedge clk) begin
        logic [26:0] w;
        if (pt_b) begin
            if (q_b.size() == 0) begin
                chk("b_extra_tick", 1, 0);
            end else begin
                w = q_b.pop_front();
                chk("b_pixel", int'({fs_b, hs_b, vs_b, hb_b, vb_b, y_b, x_b}), int'(w));
            end
            if (fs_b) begin
                fs_cnt_b++;
                if (fs_cnt_b == 1) fs_cyc1 = cyc;
                else if (fs_cnt_b == 2) fs_cyc2 = cyc;
            end
        end else begin
            chk("b_fs_without_tick", int'(fs_b), 0);
        end
        if (!en_b_q) chk("b_tick_while_disabled", int'(pt_b), 0);
    end

    always @(negedge clk) begin
        logic [26:0] w;
        if (pt_c) begin
            if (q_c.size() == 0) begin
                chk("c_extra_tick", 1, 0);
            end else begin
                w = q_c.pop_front();
                chk("c_pixel", int'({fs_c, hs_c, vs_c, hb_c, vb_c, y_c, x_c}), int'(w));
            end
        end
    end

    task automatic wait_x_a(input int val, input string nm);
        int n = 0;
        while (x_a != 11'(val) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (x_a != 11'(val)) chk(nm, int'(x_a), val);
    endtask

    task automatic phase_a();
        int first_hb = 0, hs_cnt = 0, ticks = 0, first_y1 = 0;
        chk("a_rst_x", int'(x_a), 0);
        chk("a_rst_hs", int'(hs_a), 0);
        chk("a_rst_pt", int'(pt_a), 0);
        chk("a_rst_fs", int'(fs_a), 0);
        @(negedge clk);
        rst_a = 1'b1;
        for (int n = 1; n <= 2100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("a_edge1_x", int'(x_a), 0);
                chk("a_edge1_pt", int'(pt_a), 0);
            end
            if (n == 2) begin
                chk("a_edge2_xy", int'({y_a, x_a}), 1);
                chk("a_edge2_pt", int'(pt_a), 1);
            end
            if (hb_a && first_hb == 0) first_hb = n;
            if (first_y1 == 0) begin
                if (pt_a) ticks++;
                if (hs_a) hs_cnt++;
                if (y_a == 11'd1) first_y1 = n;
            end
        end
        chk("a_hblank_rise_clk", first_hb, 1600);
        chk("a_hsync_high_clks", hs_cnt, 240);
        chk("a_line_period_clks", first_y1, 2080);
        chk("a_ticks_per_line", ticks, 1040);

        // Freeze one clock into pixel 500, so the held prescaler is mid-count.
        wait_x_a(500, "a_find_x500");
        chk("a_x500_tick", int'(pt_a), 1);
        @(negedge clk);
        en_a = 1'b0;
        for (int n = 0; n < 17; n++) begin
            @(negedge clk);
            chk("a_hold_x", int'(x_a), 500);
            chk("a_hold_pt", int'(pt_a), 0);
        end
        en_a = 1'b1;
        @(negedge clk);
        chk("a_resume_x", int'(x_a), 501);
        chk("a_resume_pt", int'(pt_a), 1);
        @(negedge clk);
        chk("a_resume_pt_low", int'(pt_a), 0);
        @(negedge clk);
        chk("a_resume_next_x", int'(x_a), 502);

        wait_x_a(900, "a_find_x900");
        chk("a_pre_rst_hs", int'(hs_a), 1);
        chk("a_pre_rst_y", int'(y_a), 1);
        #2 rst_a = 1'b0;
        #1;
        chk("a_async_rst_x", int'(x_a), 0);
        chk("a_async_rst_y", int'(y_a), 0);
        chk("a_async_rst_hb", int'(hb_a), 0);
        chk("a_async_rst_vb", int'(vb_a), 0);
        chk("a_async_rst_hs", int'(hs_a), 0);
        chk("a_async_rst_vs", int'(vs_a), 0);
        chk("a_async_rst_fs", int'(fs_a), 0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_rel_edge1_x", int'(x_a), 0);
        @(negedge clk);
        chk("a_rel_edge2_xy", int'({y_a, x_a}), 1);
        chk("a_rel_edge2_pt", int'(pt_a), 1);
    endtask

    task automatic phase_b();
        int c = 0;
        chk("b_rst_hs", int'(hs_b), 0);
        chk("b_rst_vs", int'(vs_b), 0);
        for (int k = 1; k <= 306; k++) q_b.push_back(exp_word(k, 1'b1));
        @(negedge clk);
        rst_b = 1'b1;
        while (q_b.size() != 0 && c < 1500) begin
            @(negedge clk);
            c++;
            en_b = !((c >= 50 && c < 57) || (c >= 100 && c < 104));
        end
        #1 rst_b = 1'b0;
        en_b = 1'b1;
        chk("b_queue_left", q_b.size(), 0);
        chk("b_frame_starts", fs_cnt_b, 2);
        chk("b_frame_period", fs_cyc2 - fs_cyc1, 459);
    endtask

    task automatic phase_c();
        chk("c_rst_hs", int'(hs_c), 1);
        chk("c_rst_vs", int'(vs_c), 1);
        chk("c_rst_pt", int'(pt_c), 0);
        for (int k = 1; k <= 160; k++) q_c.push_back(exp_word(k, 1'b0));
        @(negedge clk);
        rst_c = 1'b1;
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            chk("c_tick_every_clk", int'(pt_c), 1);
        end
        #1 rst_c = 1'b0;
        @(negedge clk);
        chk("c_queue_left", q_c.size(), 0);
    endtask

    initial begin
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        @(negedge clk);
        @(negedge clk);
        phase_a();
        phase_b();
        phase_c();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
